fifo_word_unpacker: RTL
=======================

# fifo_word_unpacker

Downstream drain stage for the synchronous word FIFO. It pops 32-bit words through the FIFO's read strobe and registered data output, and serialises each word into bytes on a valid/ready stream toward the byte-wide transmit path. It also tracks how many words have been fully drained.

## Interface
- WORD_WIDTH, 32, FIFO word width; must be an integer multiple of BYTE_WIDTH, with ratio ≥ 2
- BYTE_WIDTH, 8, output symbol width
- MSB_FIRST, 1, 1: first byte out is word[WORD_WIDTH-1 -: BYTE_WIDTH]; 0: first byte out is word[BYTE_WIDTH-1:0]
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- en  input  1  permits new FIFO reads; a word already fetched always completes
- fifo_empty  input  1  FIFO empty flag
- fifo_dout  input  WORD_WIDTH  FIFO registered data output, valid the cycle after a read
- fifo_rd  output  1  FIFO read strobe, combinational, one cycle per word
- out_data  output  BYTE_WIDTH  current byte
- out_valid  output  1  out_data is valid
- out_ready  input  1  sink accepts the byte
- out_last  output  1  out_data is the final byte of its word
- busy  output  1  high in any state other than IDLE
- word_cnt  output  16  count of fully transferred words, wraps 0xFFFF→0

## Operation
- BYTES = WORD_WIDTH/BYTE_WIDTH. Internal state: shift register of WORD_WIDTH bits; byte index of $clog2(BYTES) bits.
- FSM states: IDLE, WAIT, SHIFT.
- fifo_rd = rst_n && en && !fifo_empty && (state==IDLE || (state==SHIFT && out_last && out_ready)).
- IDLE: if fifo_rd, go to WAIT. Otherwise stay in IDLE.
- WAIT: load shift register from fifo_dout, set index to 0, go to SHIFT. This state is unconditional and lasts one cycle.
- SHIFT: out_valid=1. On each edge where out_valid && out_ready:
  - If not the last byte, shift by BYTE_WIDTH toward the output end and increment index.
  - If the last byte, increment word_cnt, then go to WAIT if fifo_rd was high in that cycle, else go to IDLE.
- out_last = (state==SHIFT) && (index==BYTES-1).
- out_data is driven from the output end of the shift register and is 0 outside SHIFT.
- Stall rule: while out_valid && !out_ready, out_data, out_last, the index and the shift register all hold.
- en deasserted mid-word: the current word drains fully. No further fifo_rd until en returns high.
- A FIFO underflow request is impossible: fifo_rd is never asserted while fifo_empty=1.
- fifo_rd is never asserted on two consecutive cycles. fifo_empty therefore always reflects the previous pop.
- Reset (any time, including mid-word):
  - state returns to IDLE; the partial word is discarded and never re-emitted.
  - All outputs go to 0: fifo_rd, out_data, out_valid, out_last, busy, word_cnt. The shift register and index are also cleared.

## Timing
- Cycle N: fifo_rd=1 is sampled by the FIFO.
- Cycle N+1: state is WAIT and fifo_dout is valid; it is captured at the end of N+1.
- Cycle N+2: out_valid=1 with byte 0.
- Latency from the read strobe to the first byte is 2 cycles.
- With out_ready held at 1: bytes appear on N+2 .. N+1+BYTES. The next fifo_rd coincides with the last byte. Throughput is BYTES bytes per BYTES+1 cycles (5 cycles per word at the defaults).
- No combinational path from out_ready to out_data or out_valid. out_ready reaches fifo_rd only through out_last gating.
- word_cnt updates on the edge that accepts the last byte.

## Test plan
- Single word at defaults:
  - Stimulus: FIFO holds 0xA1B2C3D4, en=1, out_ready=1.
  - Response: fifo_rd high for 1 cycle. Two cycles later out_data sequence is A1,B2,C3,D4 with out_last only on D4. word_cnt=1, then IDLE and busy=0.
- Back-to-back words:
  - Stimulus: 3 words queued, out_ready=1.
  - Response: 15 cycles from the first fifo_rd to the last byte. Exactly one bubble cycle (WAIT) between words. word_cnt=3. fifo_rd never high on adjacent cycles.
- Backpressure:
  - Stimulus: out_ready toggles 1,0,0,1,... during word 0x11223344.
  - Response: out_data holds each byte through stall cycles. Output order is 11,22,33,44. No extra FIFO read while stalled on the last byte.
- LSB-first and en gating:
  - Stimulus: MSB_FIRST=0 with word 0xA1B2C3D4. Separately, drop en during byte 1 with 2 words queued.
  - Response: output is D4,C3,B2,A1. The current word completes; no fifo_rd until en=1; fifo_empty is honoured.
- Reset mid-word:
  - Stimulus: assert rst_n=0 after byte 1 is accepted, then release with the FIFO still non-empty.
  - Response: all outputs go to 0 immediately. After release, a fresh fifo_rd is issued and output starts at byte 0 of the next word. word_cnt restarts at 0.
- word_cnt wrap:
  - Stimulus: preload via 65536 word transfers (or a forced counter).
  - Response: word_cnt goes 0xFFFF→0x0000 with no side effects.

Source files
------------

// File: rtl/fifo_word_unpacker.sv
// fifo_word_unpacker: drains 32-bit words from a synchronous FIFO and
// serialises each one into bytes on a valid/ready stream. A word is popped with
// a single-cycle read strobe, captured one cycle later from the FIFO's
// registered output, then shifted out byte by byte. A 16-bit counter tracks
// fully drained words.
module fifo_word_unpacker #(
  parameter int WORD_WIDTH = 32,
  parameter int BYTE_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  fifo_empty,
  input  logic [WORD_WIDTH-1:0] fifo_dout,
  output logic                  fifo_rd,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic [15:0]           word_cnt
);

  localparam int BYTES = WORD_WIDTH / BYTE_WIDTH;
  localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_SHIFT = 2'd2
  } state_t;

  state_t                  state_reg, state_next;
  logic [WORD_WIDTH-1:0]   shift_reg, shift_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [15:0]             word_cnt_reg, word_cnt_next;

  logic [BYTE_WIDTH-1:0]   head_byte;
  logic [WORD_WIDTH-1:0]   shift_advanced;
  logic                    in_shift;
  logic                    last_byte;

  assign in_shift  = (state_reg == ST_SHIFT);
  assign last_byte = in_shift && (idx_reg == LAST_IDX);

  // The output end of the shift register depends on byte order: the head byte
  // is taken from that end and the remaining bytes move toward it.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign head_byte      = shift_reg[WORD_WIDTH-1 -: BYTE_WIDTH];
      assign shift_advanced = {shift_reg[WORD_WIDTH-BYTE_WIDTH-1:0], {BYTE_WIDTH{1'b0}}};
    end else begin : g_lsb_first
      assign head_byte      = shift_reg[BYTE_WIDTH-1:0];
      assign shift_advanced = {{BYTE_WIDTH{1'b0}}, shift_reg[WORD_WIDTH-1:BYTE_WIDTH]};
    end
  endgenerate

  // A new word may be requested from IDLE, or on the very cycle the final
  // byte of the current word is accepted, so the strobe can never repeat on
  // adjacent cycles (the intervening WAIT cycle blocks it). Gating with rst_n
  // forces the strobe low as soon as reset is applied.
  assign fifo_rd = rst_n && en && !fifo_empty &&
                   ((state_reg == ST_IDLE) || (last_byte && out_ready));

  assign out_valid = in_shift;
  assign out_last  = last_byte;
  assign out_data  = in_shift ? head_byte : {BYTE_WIDTH{1'b0}};
  assign busy      = (state_reg != ST_IDLE);
  assign word_cnt  = word_cnt_reg;

  // State register, shift register, byte index and word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      shift_reg    <= '0;
      idx_reg      <= '0;
      word_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      shift_reg    <= shift_next;
      idx_reg      <= idx_next;
      word_cnt_reg <= word_cnt_next;
    end
  end

  // Next-state logic: fetch in IDLE, capture in WAIT, serialise in SHIFT.
  // Everything holds while a byte is presented but not accepted.
  always_comb begin
    state_next    = state_reg;
    shift_next    = shift_reg;
    idx_next      = idx_reg;
    word_cnt_next = word_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (fifo_rd) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        shift_next = fifo_dout;
        idx_next   = '0;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (out_ready) begin
          if (last_byte) begin
            word_cnt_next = word_cnt_reg + 16'd1;
            state_next    = fifo_rd ? ST_WAIT : ST_IDLE;
          end else begin
            shift_next = shift_advanced;
            idx_next   = idx_reg + 1'b1;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

endmodule
